// File: rtl/hex_scan_mux.sv
// Multiplexed hex display scanner with double-buffered value and dark inter-digit cycle.
// Define HEX_SCAN_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module hex_scan_mux #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   pend_val;
    logic [4*DIGITS-1:0]   shifted;
    logic                  pend;
    logic                  slot_end;
    logic                  wrap;
    logic [DIGITS-1:0]     vis;

    assign slot_end = en && (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign pending  = pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            disp        <= '0;
            pend_val    <= '0;
            pend        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                pend_val <= value;
            end
            // A load on the wrap edge bypasses the buffer so the newest value wins.
            if (wrap) begin
                if (load) begin
                    disp <= value;
                end else if (pend) begin
                    disp <= pend_val;
                end
                pend <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

`ifdef HEX_SCAN_BLANK_EN
    logic seen;
    always_comb begin
        seen = 1'b0;
        vis  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen   = seen | (disp[4*i +: 4] != 4'd0);
            vis[i] = seen || (i == 0);
        end
    end
`else
    always_comb begin
        vis = '1;
    end
`endif

    always_comb begin
        shifted = disp >> {idx, 2'b00};
        data    = shifted[3:0];
        dig     = '0;
        if (en && (cnt != '0)) begin
            dig = vis & (DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Bench for hex_scan_mux: directed frame table plus randomized run vs. a tick-count model.
// Expectations follow HEX_SCAN_BLANK_EN when it is defined.
module tb_hex_scan_mux;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
`ifdef HEX_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  data;
    logic [3:0]  dig;
    logic        frame_start;
    logic        pending;

    hex_scan_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
        .data(data), .dig(dig), .frame_start(frame_start),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the scan position is just the count of enabled clocks since reset.
    int          ticks;
    logic [15:0] mdisp;
    logic [15:0] mpv;
    bit          mpend;
    bit          mfs;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [3:0] data;
        logic       fs;
        logic       pend;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int c, logic [3:0] d, logic [3:0] n,
                                logic f, logic p);
        vec_t v;
        v.cyc = c; v.dig = d; v.data = n; v.fs = f; v.pend = p;
        tbl.push_back(v);
    endfunction

    function automatic logic [3:0] bd(logic [3:0] d);
        return BLANK ? 4'd0 : d;
    endfunction

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, act, exp);
        end
    endtask

    function automatic logic [3:0] m_data();
        int d = (ticks / CLK_DIV) % DIGITS;
        return 4'((mdisp >> (4 * d)) & 16'hF);
    endfunction

    function automatic logic [3:0] m_dig(bit e);
        int pos = ticks % CLK_DIV;
        int d   = (ticks / CLK_DIV) % DIGITS;
        if (!e || pos == 0) return 4'd0;
        if (BLANK && d > 0 && (mdisp >> (4 * d)) == 16'd0) return 4'd0;
        return 4'(1 << d);
    endfunction

    function automatic void m_step(bit r, bit e, bit l, logic [15:0] v);
        bit wrap;
        if (r) begin
            ticks = 0; mdisp = '0; mpv = '0; mpend = 0; mfs = 0;
            return;
        end
        wrap = e && (ticks % CLK_DIV == CLK_DIV - 1) &&
               ((ticks / CLK_DIV) % DIGITS == DIGITS - 1);
        mfs = wrap;
        if (l) mpv = v;
        if (wrap) begin
            if (l) mdisp = v;
            else if (mpend) mdisp = mpv;
            mpend = 0;
        end else if (l) begin
            mpend = 1;
        end
        if (e) ticks++;
    endfunction

    task automatic model_check(int c);
        chk("m_data", c, data, m_data());
        chk("m_dig", c, dig, m_dig(en));
        chk("m_fs", c, frame_start, mfs);
        chk("m_pend", c, pending, mpend);
    endtask

    initial begin
        add(0,   4'h0,     4'h0, 0, 0);
        add(1,   4'h1,     4'h0, 0, 0);
        add(3,   4'h1,     4'h0, 0, 0);
        add(4,   4'h0,     4'h0, 0, 0);
        add(5,   bd(4'h2), 4'h0, 0, 0);
        add(7,   bd(4'h2), 4'h0, 0, 1);
        add(13,  bd(4'h8), 4'h0, 0, 1);
        add(15,  bd(4'h8), 4'h0, 0, 1);
        add(16,  4'h0,     4'h4, 1, 0);
        add(17,  4'h1,     4'h4, 0, 0);
        add(21,  4'h2,     4'h3, 0, 0);
        add(25,  4'h4,     4'h2, 0, 0);
        add(29,  4'h8,     4'h1, 0, 0);
        add(32,  4'h0,     4'h4, 1, 0);
        add(36,  4'h0,     4'h3, 0, 1);
        add(45,  4'h8,     4'h1, 0, 1);
        add(48,  4'h0,     4'hF, 1, 0);
        add(53,  4'h2,     4'hE, 0, 0);
        add(57,  4'h4,     4'hE, 0, 0);
        add(61,  4'h8,     4'hB, 0, 0);
        add(63,  4'h8,     4'hB, 0, 0);
        add(64,  4'h0,     4'hE, 1, 0);
        add(65,  4'h1,     4'hE, 0, 0);
        add(69,  4'h2,     4'hD, 0, 0);
        add(73,  4'h4,     4'h0, 0, 0);
        add(74,  4'h0,     4'h0, 0, 0);
        add(80,  4'h0,     4'h0, 0, 0);
        add(84,  4'h4,     4'h0, 0, 0);
        add(85,  4'h4,     4'h0, 0, 0);
        add(86,  4'h0,     4'hC, 0, 0);
        add(90,  4'h0,     4'hE, 1, 0);
        add(93,  4'h1,     4'hE, 0, 1);
        add(107, 4'h1,     4'h0, 0, 0);
        add(111, 4'h2,     4'h5, 0, 0);
        add(115, bd(4'h4), 4'h0, 0, 0);
        add(119, bd(4'h8), 4'h0, 0, 0);
        add(127, 4'h2,     4'h5, 0, 1);
        add(139, 4'h1,     4'h0, 0, 0);
        add(143, bd(4'h2), 4'h0, 0, 0);
        add(147, bd(4'h4), 4'h0, 0, 0);

        rst = 1'b1; en = 1'b1; load = 1'b0; value = '0;
        m_step(1, 0, 0, '0);
        repeat (3) @(posedge clk);

        for (int c = 0; c <= 150; c++) begin
            @(negedge clk);
            rst   = 1'b0;
            en    = !(c >= 74 && c <= 83);
            load  = 1'b0;
            value = 16'h0;
            case (c)
                6:   begin load = 1'b1; value = 16'h1234; end
                35:  begin load = 1'b1; value = 16'hAAAA; end
                41:  begin load = 1'b1; value = 16'hBEEF; end
                63:  begin load = 1'b1; value = 16'hC0DE; end
                92:  begin load = 1'b1; value = 16'h0050; end
                125: begin load = 1'b1; value = 16'h0000; end
                default: ;
            endcase
            #1;
            model_check(c);
            foreach (tbl[k]) begin
                if (tbl[k].cyc == c) begin
                    chk("t_dig", c, dig, tbl[k].dig);
                    chk("t_data", c, data, tbl[k].data);
                    chk("t_fs", c, frame_start, tbl[k].fs);
                    chk("t_pend", c, pending, tbl[k].pend);
                end
            end
            m_step(rst, en, load, value);
        end

        // Mid-frame reset must discard the pending value.
        @(negedge clk);
        load = 1'b1; value = 16'h9999; #1;
        m_step(0, en, load, value);
        @(negedge clk);
        load = 1'b0; rst = 1'b1; #1;
        chk("pend_before_rst", 0, pending, 1'b1);
        m_step(1, en, 0, '0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_pend", 0, pending, 1'b0);
        chk("rst_dig", 0, dig, 4'h0);
        chk("rst_data", 0, data, 4'h0);
        chk("rst_fs", 0, frame_start, 1'b0);
        m_step(0, en, 0, '0);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst   = ($urandom % 97) == 0;
            en    = ($urandom % 8) != 0;
            load  = ($urandom % 13) == 0;
            value = 16'($urandom);
            if (($urandom % 4) == 0) value = value & 16'h00FF;
            #1;
            model_check(1000 + c);
            m_step(rst, en, load, value);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
